// File: rtl/cache_ctrl_l1_data.sv
// L1 data-cache controller: load/store lookup, L2 refill on load miss,
// write-through/no-write-allocate stores, L2 timeout, hit/miss statistics.
module cache_ctrl_l1_data #(
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    output logic              core_done_o,
    output logic              core_err_o,
    input  logic              cache_hit_i,
    output logic [ADDR_W-1:0] cache_addr_o,
    output logic              cache_read_o,
    output logic              cache_write_o,
    output logic              write_L2_o,
    output logic              write_through_o,
    output logic              l2_req_o,
    output logic              l2_we_o,
    input  logic              l2_ack_i,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, L2_RD, FILL, L2_WR, DONE, ERR
    } state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   hit_d, miss_d;
    logic               done_d, err_d, rd_d, wr_d, wl2_d, wt_d, l2req_d, l2we_d;

    // Next state, counters, and control outputs decoded from the next state
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = cache_addr_o;
        tmo_d   = tmo_q;
        hit_d   = hit_cnt_o;
        miss_d  = miss_cnt_o;

        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    addr_d  = core_addr_i;
                    we_d    = core_we_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                tmo_d = '0;
                if (cache_hit_i) begin
                    if (!(&hit_cnt_o)) hit_d = hit_cnt_o + CNT_W'(1);
                end else begin
                    if (!(&miss_cnt_o)) miss_d = miss_cnt_o + CNT_W'(1);
                end
                if (we_q)             state_d = L2_WR;
                else if (cache_hit_i) state_d = DONE;
                else                  state_d = L2_RD;
            end
            L2_RD: begin
                if (l2_ack_i)              state_d = FILL;
                else if (tmo_q == TMO_LAST) state_d = ERR;
                else                        tmo_d = tmo_q + TMO_W'(1);
            end
            FILL:    state_d = LOOKUP;
            L2_WR: begin
                if (l2_ack_i)              state_d = DONE;
                else if (tmo_q == TMO_LAST) state_d = ERR;
                else                        tmo_d = tmo_q + TMO_W'(1);
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        done_d  = (state_d == DONE) || (state_d == ERR);
        err_d   = (state_d == ERR);
        rd_d    = (state_d == LOOKUP) && !we_d;
        wt_d    = (state_d == LOOKUP) && we_d;
        wr_d    = wt_d || (state_d == FILL);
        wl2_d   = (state_d == FILL);
        l2req_d = (state_d == L2_RD) || (state_d == L2_WR);
        l2we_d  = (state_d == L2_WR);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            we_q            <= 1'b0;
            tmo_q           <= '0;
            cache_addr_o    <= '0;
            hit_cnt_o       <= '0;
            miss_cnt_o      <= '0;
            core_done_o     <= 1'b0;
            core_err_o      <= 1'b0;
            cache_read_o    <= 1'b0;
            cache_write_o   <= 1'b0;
            write_L2_o      <= 1'b0;
            write_through_o <= 1'b0;
            l2_req_o        <= 1'b0;
            l2_we_o         <= 1'b0;
        end else begin
            state_q         <= state_d;
            we_q            <= we_d;
            tmo_q           <= tmo_d;
            cache_addr_o    <= addr_d;
            hit_cnt_o       <= hit_d;
            miss_cnt_o      <= miss_d;
            core_done_o     <= done_d;
            core_err_o      <= err_d;
            cache_read_o    <= rd_d;
            cache_write_o   <= wr_d;
            write_L2_o      <= wl2_d;
            write_through_o <= wt_d;
            l2_req_o        <= l2req_d;
            l2_we_o         <= l2we_d;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_l1_data.sv
// Bench for cache_ctrl_l1_data: tag-array cache model, L2 responder and
// completion scoreboard, with TIMEOUT=4 and CNT_W=2.
module tb_cache_ctrl_l1_data;

    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_req, core_we, core_done, core_err;
    logic [ADDR_W-1:0] core_addr, cache_addr;
    logic              cache_hit, cache_read, cache_write, write_l2, write_through;
    logic              l2_req, l2_we, l2_ack;
    logic [CNT_W-1:0]  hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    cache_ctrl_l1_data #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
        .core_done_o(core_done), .core_err_o(core_err),
        .cache_hit_i(cache_hit), .cache_addr_o(cache_addr),
        .cache_read_o(cache_read), .cache_write_o(cache_write),
        .write_L2_o(write_l2), .write_through_o(write_through),
        .l2_req_o(l2_req), .l2_we_o(l2_we), .l2_ack_i(l2_ack),
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    // Cache tag model: idx = addr[9:4], tag = addr[18:10]
    logic       valid_m [64];
    logic [8:0] tag_m   [64];
    assign cache_hit = valid_m[cache_addr[9:4]] && (tag_m[cache_addr[9:4]] == cache_addr[18:10]);

    typedef struct { logic err; int lat; } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int passes = 0;

    function automatic logic present(input logic [ADDR_W-1:0] a);
        return valid_m[a[9:4]] && (tag_m[a[9:4]] == a[18:10]);
    endfunction

    task automatic preload(input logic [ADDR_W-1:0] a);
        valid_m[a[9:4]] = 1'b1;
        tag_m[a[9:4]]   = a[18:10];
    endtask

    // Advance one clock; a fill cycle allocates the line before the edge
    task automatic step();
        if (cache_write && write_l2) begin
            valid_m[cache_addr[9:4]] = 1'b1;
            tag_m[cache_addr[9:4]]   = cache_addr[18:10];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; core_req = 1'b0; l2_ack = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    // Issue one request, act as L2 (ack on the ack_at-th L2 cycle, 0 = never),
    // and score the completion against the queued expectation.
    task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr, input int ack_at,
                          input logic exp_err, input int exp_lat,
                          output int l2c, output int fills, output logic rd1,
                          output logic wr1, output logic addr_ok, output logic we_ok);
        exp_t e;
        int   n;
        logic done;
        sb_q.push_back('{err: exp_err, lat: exp_lat});
        core_we = we; core_addr = addr; core_req = 1'b1;
        n = 0; done = 1'b0; l2c = 0; fills = 0; rd1 = 1'b0; wr1 = 1'b0;
        addr_ok = 1'b1; we_ok = 1'b1;
        while (!done && n < 64) begin
            step();
            n++;
            l2_ack = 1'b0;
            if (n == 1) begin rd1 = cache_read; wr1 = cache_write; end
            if (cache_addr !== addr) addr_ok = 1'b0;
            if (write_l2 && cache_write) fills++;
            if (l2_req) begin
                l2c++;
                if (l2_we !== we) we_ok = 1'b0;
                if (ack_at > 0 && l2c == ack_at) l2_ack = 1'b1;
            end
            if (core_done) begin
                done = 1'b1;
                core_req = 1'b0;
                e = sb_q.pop_front();
                checks++;
                if (core_err !== e.err) $display("FAIL done_err addr=%h: got %b expected %b", addr, core_err, e.err);
                else passes++;
                checks++;
                if (n != e.lat) $display("FAIL latency addr=%h: got %0d expected %0d", addr, n, e.lat);
                else passes++;
            end
        end
        if (!done) begin
            checks++;
            $display("FAIL req_timeout addr=%h: no core_done_o within 64 cycles", addr);
            core_req = 1'b0;
            e = sb_q.pop_front();
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; core_req = 1'b1; core_we = 1'b0; core_addr = 19'h01234; l2_ack = 1'b1;
        step(); step();
        l2_ack = 1'b0;
        checks++; if (core_done !== 1'b0) $display("FAIL rst_done: got %b expected 0", core_done); else passes++;
        checks++; if (l2_req !== 1'b0) $display("FAIL rst_l2_req: got %b expected 0", l2_req); else passes++;
        checks++; if ({cache_read, cache_write, write_l2, write_through, l2_we, core_err} !== 6'b0)
            $display("FAIL rst_ctrl: got %b expected 000000", {cache_read, cache_write, write_l2, write_through, l2_we, core_err});
        else passes++;
        checks++; if (cache_addr !== '0) $display("FAIL rst_addr: got %h expected 0", cache_addr); else passes++;
        checks++; if (hit_cnt !== '0 || miss_cnt !== '0) $display("FAIL rst_cnt: got %0d/%0d expected 0/0", hit_cnt, miss_cnt); else passes++;
        // Request held through reset is taken on the first cycle afterwards
        rst = 1'b0;
        step();
        checks++; if (cache_read !== 1'b1) $display("FAIL rst_accept_read: got %b expected 1", cache_read); else passes++;
        checks++; if (cache_addr !== 19'h01234) $display("FAIL rst_accept_addr: got %h expected 01234", cache_addr); else passes++;
        step();
        checks++; if (core_done !== 1'b1) $display("FAIL rst_accept_done: got %b expected 1", core_done); else passes++;
        core_req = 1'b0;
        step();
    endtask

    task automatic test_load_hit();
        int l2c, fills; logic rd1, wr1, aok, wok;
        do_reset();
        do_req(1'b0, 19'h01234, 0, 1'b0, 2, l2c, fills, rd1, wr1, aok, wok);
        checks++; if (rd1 !== 1'b1 || wr1 !== 1'b0) $display("FAIL hit_lookup_ctrl: got rd=%b wr=%b expected rd=1 wr=0", rd1, wr1); else passes++;
        checks++; if (l2c != 0 || fills != 0) $display("FAIL hit_no_l2: got l2=%0d fill=%0d expected 0/0", l2c, fills); else passes++;
        checks++; if (hit_cnt !== 2'd1 || miss_cnt !== 2'd0) $display("FAIL hit_cnt: got %0d/%0d expected 1/0", hit_cnt, miss_cnt); else passes++;
    endtask

    task automatic test_load_miss();
        int l2c, fills; logic rd1, wr1, aok, wok;
        do_reset();
        do_req(1'b0, 19'h02468, 3, 1'b0, 7, l2c, fills, rd1, wr1, aok, wok);
        checks++; if (l2c != 3) $display("FAIL miss_l2_cycles: got %0d expected 3", l2c); else passes++;
        checks++; if (fills != 1) $display("FAIL miss_fill: got %0d expected 1", fills); else passes++;
        checks++; if (wok !== 1'b1) $display("FAIL miss_l2_we: got bad=%b expected l2_we_o=0", !wok); else passes++;
        checks++; if (aok !== 1'b1) $display("FAIL miss_addr_stable: got %b expected 1", aok); else passes++;
        checks++; if (hit_cnt !== 2'd1 || miss_cnt !== 2'd1) $display("FAIL miss_cnt: got %0d/%0d expected 1/1", hit_cnt, miss_cnt); else passes++;
        checks++; if (present(19'h02468) !== 1'b1) $display("FAIL miss_allocated: got %b expected 1", present(19'h02468)); else passes++;
    endtask

    task automatic test_store();
        int l2c, fills; logic rd1, wr1, aok, wok;
        do_reset();
        do_req(1'b1, 19'h03000, 2, 1'b0, 4, l2c, fills, rd1, wr1, aok, wok);
        checks++; if (rd1 !== 1'b0 || wr1 !== 1'b1) $display("FAIL st_lookup_ctrl: got rd=%b wr=%b expected rd=0 wr=1", rd1, wr1); else passes++;
        checks++; if (l2c != 2 || wok !== 1'b1) $display("FAIL st_l2: got cycles=%0d we_ok=%b expected 2/1", l2c, wok); else passes++;
        checks++; if (fills != 0) $display("FAIL st_no_fill: got %0d expected 0", fills); else passes++;
        checks++; if (present(19'h03000) !== 1'b0) $display("FAIL st_no_alloc: got %b expected 0", present(19'h03000)); else passes++;
        checks++; if (hit_cnt !== 2'd0 || miss_cnt !== 2'd1) $display("FAIL st_miss_cnt: got %0d/%0d expected 0/1", hit_cnt, miss_cnt); else passes++;
        do_req(1'b1, 19'h01234, 1, 1'b0, 3, l2c, fills, rd1, wr1, aok, wok);
        checks++; if (hit_cnt !== 2'd1 || miss_cnt !== 2'd1) $display("FAIL st_hit_cnt: got %0d/%0d expected 1/1", hit_cnt, miss_cnt); else passes++;
    endtask

    task automatic test_timeout();
        int l2c, fills; logic rd1, wr1, aok, wok;
        do_reset();
        do_req(1'b0, 19'h04100, 0, 1'b1, 6, l2c, fills, rd1, wr1, aok, wok);
        checks++; if (l2c != 4) $display("FAIL tmo_l2_cycles: got %0d expected 4", l2c); else passes++;
        checks++; if (fills != 0) $display("FAIL tmo_no_fill: got %0d expected 0", fills); else passes++;
        // Ack on the last allowed cycle wins over the timeout
        do_req(1'b0, 19'h04200, 4, 1'b0, 8, l2c, fills, rd1, wr1, aok, wok);
        checks++; if (l2c != 4 || fills != 1) $display("FAIL tmo_ack_wins: got l2=%0d fill=%0d expected 4/1", l2c, fills); else passes++;
        do_req(1'b1, 19'h04300, 4, 1'b0, 6, l2c, fills, rd1, wr1, aok, wok);
        checks++; if (l2c != 4 || wok !== 1'b1) $display("FAIL tmo_st_ack: got l2=%0d we_ok=%b expected 4/1", l2c, wok); else passes++;
        do_req(1'b1, 19'h04400, 0, 1'b1, 6, l2c, fills, rd1, wr1, aok, wok);
        checks++; if (miss_cnt !== 2'd3) $display("FAIL tmo_miss_sat: got %0d expected 3", miss_cnt); else passes++;
    endtask

    task automatic test_ack_ignored();
        logic bad;
        do_reset();
        bad = 1'b0;
        l2_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (core_done !== 1'b0 || l2_req !== 1'b0 || cache_read !== 1'b0) bad = 1'b1;
        end
        l2_ack = 1'b0;
        checks++; if (bad !== 1'b0) $display("FAIL idle_ack_ignored: got activity=%b expected 0", bad); else passes++;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        core_we = 1'b0; core_addr = 19'h05550; core_req = 1'b1;
        n = 0;
        while (l2_req !== 1'b1 && n < 16) begin step(); n++; end
        checks++; if (l2_req !== 1'b1) $display("FAIL rmid_enter_l2: got %b expected 1", l2_req); else passes++;
        step();
        rst = 1'b1;
        step();
        checks++; if (l2_req !== 1'b0 || core_done !== 1'b0) $display("FAIL rmid_l2_req: got req=%b done=%b expected 0/0", l2_req, core_done); else passes++;
        checks++; if (hit_cnt !== '0 || miss_cnt !== '0) $display("FAIL rmid_cnt: got %0d/%0d expected 0/0", hit_cnt, miss_cnt); else passes++;
        rst = 1'b0; core_req = 1'b0;
        step();
        checks++; if (cache_read !== 1'b0 || l2_req !== 1'b0) $display("FAIL rmid_idle: got rd=%b l2=%b expected 0/0", cache_read, l2_req); else passes++;
    endtask

    task automatic test_back_to_back_sat();
        int l2c, fills; logic rd1, wr1, aok, wok;
        int exp;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            do_req(1'b0, 19'h01234, 0, 1'b0, 2, l2c, fills, rd1, wr1, aok, wok);
            exp = (k > 3) ? 3 : k;
            checks++;
            if (int'(hit_cnt) != exp) $display("FAIL sat_hit_cnt k=%0d: got %0d expected %0d", k, hit_cnt, exp);
            else passes++;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin valid_m[i] = 1'b0; tag_m[i] = '0; end
        rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_addr = '0; l2_ack = 1'b0;
        preload(19'h01234);
        test_reset();
        test_load_hit();
        test_load_miss();
        test_store();
        test_timeout();
        test_ack_ignored();
        test_reset_mid();
        test_back_to_back_sat();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_l1_data.md
CACHE_CTRL_L1_DATA -- requirements
Module: cache_ctrl_l1_data

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, core byte-address width (tag 9 + idx 6 + word 2 + offset 2).
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waiting for l2_ack_i before error.
REQ-003 SHALL have parameter CNT_W, default 16, width of hit/miss counters.
REQ-004 clk_i  in  1  single clock, all state updates on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 core_req_i  in  1  core request, held high until core_done_o.
REQ-007 core_we_i  in  1  1 = store, 0 = load; sampled with core_req_i.
REQ-008 core_addr_i  in  ADDR_W  request address; sampled with core_req_i.
REQ-009 core_done_o  out  1  one-cycle completion pulse.
REQ-010 core_err_o  out  1  qualifies core_done_o: L2 timeout.
REQ-011 cache_hit_i  in  1  hit from L1 data cache, combinational on cache_addr_o.
REQ-012 cache_addr_o  out  ADDR_W  latched request address to cache and L2.
REQ-013 cache_read_o, cache_write_o, write_L2_o, write_through_o  out  1 each  cache datapath controls.
REQ-014 l2_req_o  out  1  L2 request; l2_we_o  out  1  L2 write; l2_ack_i  in  1  L2 completion, one cycle.
REQ-015 hit_cnt_o, miss_cnt_o  out  CNT_W  lookup statistics.

Function
REQ-016 SHALL implement FSM states IDLE, LOOKUP, L2_RD, FILL, L2_WR, DONE, ERR.
REQ-017 IDLE: on core_req_i=1, latch addr/we into registers, go LOOKUP; otherwise stay.
REQ-018 LOOKUP: assert cache_read_o=!we_q, cache_write_o=we_q, write_through_o=we_q.
REQ-019 LOOKUP transitions: load hit -> DONE; load miss -> L2_RD; store (hit or miss) -> L2_WR.
REQ-020 Store policy: write-through, no-write-allocate; store miss SHALL NOT modify the cache.
REQ-021 L2_RD: l2_req_o=1, l2_we_o=0; on l2_ack_i -> FILL.
REQ-022 FILL: exactly one cycle, write_L2_o=1, cache_write_o=1; then -> LOOKUP (replay; guaranteed hit).
REQ-023 L2_WR: l2_req_o=1, l2_we_o=1; on l2_ack_i -> DONE.
REQ-024 DONE: core_done_o=1, core_err_o=0, one cycle -> IDLE; ERR: core_done_o=1, core_err_o=1, one cycle -> IDLE.
REQ-025 Timeout counter SHALL clear on entry to L2_RD/L2_WR, increment each cycle without ack; reaching TIMEOUT -> ERR, l2_req_o dropped.
REQ-026 l2_ack_i arriving in same cycle counter reaches TIMEOUT SHALL take ack path (ack wins).
REQ-027 l2_ack_i outside L2_RD/L2_WR SHALL be ignored.
REQ-028 hit_cnt_o +1 per LOOKUP with cache_hit_i=1, miss_cnt_o +1 per LOOKUP with cache_hit_i=0; replay lookups counted; both saturate at all-ones.
REQ-029 All control outputs SHALL be 0 in states not listed as asserting them; outputs decoded from registered state only plus cache_hit_i-driven transitions.
REQ-030 Latency: load hit done 2 cycles after core_req_i sampled; load miss with ack at first L2_RD cycle done 5 cycles after.
REQ-031 cache_addr_o SHALL remain constant from LOOKUP entry until return to IDLE.

Reset
REQ-032 rst_i=1 at a clock edge SHALL force IDLE from any state, including mid-L2 transaction, and clear counters and timeout counter.
REQ-033 Reset values: all 1-bit outputs 0, cache_addr_o 0, hit_cnt_o 0, miss_cnt_o 0.
REQ-034 Request present during reset SHALL be accepted on first cycle after rst_i falls.

Verification
REQ-035 Load hit: preloaded line, req load 0x1234 -> cache_read_o in cycle 1, core_done_o in cycle 2, hit_cnt_o=1.
REQ-036 Load miss: ack after 3 L2_RD cycles -> one FILL pulse with write_L2_o=1, replay hit, done err=0, miss_cnt_o=1, hit_cnt_o=1.
REQ-037 Store miss: L2_WR with l2_we_o=1, ack -> done; cache content unchanged at address.
REQ-038 Timeout: TIMEOUT=4, no ack -> l2_req_o high 4 cycles, ERR, core_done_o=1 with core_err_o=1; ack at cycle 4 instead -> err=0.
REQ-039 Reset in L2_RD: rst_i pulsed -> next cycle IDLE, l2_req_o=0, counters 0.
REQ-040 Saturation: CNT_W=2, 5 hits -> hit_cnt_o=3.
